// File: rtl/seq_pkg.sv
// Shared encodings for the program sequencer: sequencing ops and FSM states.
package seq_pkg;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JUMP = 3'd1,
    OP_BRZ  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ERR  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_stack.sv
// Parametrised LIFO return stack; push/pop guarded internally against full/empty.
module seq_stack #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] cnt;
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_idx = cnt[IW-1:0];
  assign rd_idx = IW'(cnt - DW'(1));
  assign full   = (cnt == DW'(DEPTH));
  assign empty  = (cnt == '0);
  assign depth  = cnt;
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst || clr)
      cnt <= '0;
    else if (push && !full)
      cnt <= cnt + DW'(1);
    else if (pop && !empty)
      cnt <= cnt - DW'(1);
  end

  // Entries are don't-care once popped or cleared, so storage has no reset.
  always_ff @(posedge clk) begin
    if (rst && !clr && push && !full)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: registered ROM fetch address with jump/branch/call/return and a small FSM.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int                ADDR_W      = 9,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               step,
  input  logic [2:0]                         op,
  input  logic [ADDR_W-1:0]                  target,
  input  logic                               zero_flag,
  output logic [ADDR_W-1:0]                  addr,
  output logic                               running,
  output logic                               halted,
  output logic                               stack_ovf,
  output logic                               stack_unf,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt, addr_inc, stk_top;
  logic              push, pop, clr, ovf_set, unf_set;
  logic              stk_full, stk_empty;

  assign addr_inc = addr + ADDR_W'(1);

  seq_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .top   (stk_top),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr      <= RESET_ADDR;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      stack_ovf <= stack_ovf | ovf_set;
      stack_unf <= stack_unf | unf_set;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    push      = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        addr_nxt = RESET_ADDR;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (step) begin
          case (op)
            OP_JUMP: addr_nxt = target;
            OP_BRZ:  addr_nxt = zero_flag ? target : addr_inc;
            OP_CALL: begin
              if (stk_full) begin
                ovf_set   = 1'b1;
                state_nxt = ST_ERR;
              end else begin
                push     = 1'b1;
                addr_nxt = target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                unf_set   = 1'b1;
                state_nxt = ST_ERR;
              end else begin
                pop      = 1'b1;
                addr_nxt = stk_top;
              end
            end
            OP_HALT: state_nxt = ST_HALT;
            default: addr_nxt = addr_inc;  // NEXT and unused codes 6..7
          endcase
        end
      end
      ST_HALT: begin
        if (start) begin
          addr_nxt  = RESET_ADDR;
          clr       = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: ;  // ERR: frozen until reset
    endcase
  end

  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus randomized run vs a queue-based model.
module tb_program_sequencer;

  localparam int AW = 9;
  localparam int SD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0, start = 1'b0, step = 1'b0, zero_flag = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] addr;
  logic          running, halted, stack_ovf, stack_unf;
  logic [2:0]    depth;

  int checks = 0;
  int errors = 0;

  int m_addr, m_st;
  int m_stk[$];
  bit m_ovf, m_unf;

  program_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .op(op), .target(target),
    .zero_flag(zero_flag), .addr(addr), .running(running), .halted(halted),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .depth(depth)
  );

  always #5 clk = ~clk;

  // Reference behaviour for one rising edge, written from the sequencing rules.
  task automatic model_edge(input bit r, input bit s, input bit stp, input int o, input int t, input bit z);
    if (!r) begin
      m_st = M_IDLE; m_addr = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_st == M_IDLE) begin
      m_addr = 0;
      if (s) m_st = M_RUN;
    end else if (m_st == M_RUN && stp) begin
      case (o)
        1: m_addr = t;
        2: m_addr = z ? t : (m_addr + 1) % (1 << AW);
        3: if (m_stk.size() == SD) begin m_ovf = 1; m_st = M_ERR; end
           else begin m_stk.push_back((m_addr + 1) % (1 << AW)); m_addr = t; end
        4: if (m_stk.size() == 0) begin m_unf = 1; m_st = M_ERR; end
           else m_addr = m_stk.pop_back();
        5: m_st = M_HALT;
        default: m_addr = (m_addr + 1) % (1 << AW);
      endcase
    end else if (m_st == M_HALT && s) begin
      m_addr = 0; m_stk.delete(); m_st = M_RUN;
    end
  endtask

  task automatic tick(input bit r, input bit s, input bit stp, input int o, input int t, input bit z);
    rst = r; start = s; step = stp; op = o[2:0]; target = t[AW-1:0]; zero_flag = z;
    @(posedge clk);
    model_edge(r, s, stp, o, t, z);
    #1;
    rst = 1'b1; start = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset();
    tick(0, 1, 1, 3, 77, 0);
    checks++;
    if ({addr, running, halted, depth, stack_ovf, stack_unf} !== {9'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: addr=%0d run=%b halt=%b depth=%0d ovf=%b unf=%b, want all 0",
               addr, running, halted, depth, stack_ovf, stack_unf);
    end
    tick(1, 0, 1, 0, 0, 0);
    checks++;
    if (addr !== 9'd0 || running !== 1'b0) begin
      errors++; $display("FAIL idle_step_ignored: addr=%0d run=%b, want 0 0", addr, running);
    end
  endtask

  task automatic test_next();
    tick(1, 1, 0, 0, 0, 0);
    checks++;
    if (addr !== 9'd0 || running !== 1'b1) begin
      errors++; $display("FAIL start: addr=%0d run=%b, want 0 1", addr, running);
    end
    for (int i = 1; i <= 4; i++) begin
      tick(1, 0, 1, 0, 0, 0);
      checks++;
      if (addr !== 9'(i) || running !== 1'b1) begin
        errors++; $display("FAIL next_%0d: addr=%0d run=%b, want %0d 1", i, addr, running, i);
      end
    end
    tick(1, 0, 0, 1, 300, 0);
    checks++;
    if (addr !== 9'd4) begin
      errors++; $display("FAIL hold_no_step: addr=%0d, want 4", addr);
    end
  endtask

  task automatic test_wrap();
    tick(1, 0, 1, 1, 511, 0);
    checks++;
    if (addr !== 9'd511) begin errors++; $display("FAIL jump_511: addr=%0d, want 511", addr); end
    tick(1, 0, 1, 0, 0, 0);
    checks++;
    if (addr !== 9'd0) begin errors++; $display("FAIL wrap: addr=%0d, want 0", addr); end
  endtask

  task automatic test_brz();
    tick(1, 0, 1, 1, 10, 0);
    tick(1, 0, 1, 2, 40, 0);
    checks++;
    if (addr !== 9'd11) begin errors++; $display("FAIL brz_not_taken: addr=%0d, want 11", addr); end
    tick(1, 0, 1, 2, 40, 1);
    checks++;
    if (addr !== 9'd40) begin errors++; $display("FAIL brz_taken: addr=%0d, want 40", addr); end
  endtask

  task automatic test_call_ret();
    int exp_a[4] = '{100, 200, 101, 6};
    int exp_d[4] = '{1, 2, 1, 0};
    int ops[4]   = '{3, 3, 4, 4};
    int tgt[4]   = '{100, 200, 0, 0};
    tick(1, 0, 1, 1, 5, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 1, ops[i], tgt[i], 0);
      checks++;
      if (addr !== 9'(exp_a[i]) || depth !== 3'(exp_d[i])) begin
        errors++; $display("FAIL call_ret_%0d: addr=%0d depth=%0d, want %0d %0d",
                           i, addr, depth, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_overflow();
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tick(1, 0, 1, 3, 20 * i, 0);
    checks++;
    if ({stack_ovf, stack_unf, running, halted, depth, addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 9'd80}) begin
      errors++; $display("FAIL overflow: ovf=%b unf=%b run=%b halt=%b depth=%0d addr=%0d, want 1 0 0 0 4 80",
                         stack_ovf, stack_unf, running, halted, depth, addr);
    end
    tick(1, 1, 1, 4, 0, 0);
    checks++;
    if ({running, depth, addr, stack_unf} !== {1'b0, 3'd4, 9'd80, 1'b0}) begin
      errors++; $display("FAIL err_frozen: run=%b depth=%0d addr=%0d unf=%b, want 0 4 80 0",
                         running, depth, addr, stack_unf);
    end
  endtask

  task automatic test_underflow();
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 0);
    tick(1, 0, 1, 4, 0, 0);
    checks++;
    if ({stack_unf, stack_ovf, running, addr, depth} !== {1'b1, 1'b0, 1'b0, 9'd1, 3'd0}) begin
      errors++; $display("FAIL underflow: unf=%b ovf=%b run=%b addr=%0d depth=%0d, want 1 0 0 1 0",
                         stack_unf, stack_ovf, running, addr, depth);
    end
  endtask

  task automatic test_halt();
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 3, 7, 0);
    tick(1, 0, 1, 5, 0, 0);
    checks++;
    if ({halted, running, addr} !== {1'b1, 1'b0, 9'd7}) begin
      errors++; $display("FAIL halt: halt=%b run=%b addr=%0d, want 1 0 7", halted, running, addr);
    end
    tick(1, 0, 1, 0, 0, 0);
    checks++;
    if (addr !== 9'd7 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_hold: addr=%0d halt=%b, want 7 1", addr, halted);
    end
    tick(1, 1, 0, 0, 0, 0);
    checks++;
    if ({addr, running, halted, depth} !== {9'd0, 1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL restart: addr=%0d run=%b halt=%b depth=%0d, want 0 1 0 0",
                         addr, running, halted, depth);
    end
    tick(1, 0, 1, 3, 50, 0);
    tick(0, 0, 1, 3, 60, 0);
    checks++;
    if ({addr, depth, running, halted} !== {9'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_call: addr=%0d depth=%0d run=%b halt=%b, want 0 0 0 0",
                         addr, depth, running, halted);
    end
  endtask

  task automatic test_random();
    bit r, s, stp, z;
    tick(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      r   = (m_st == M_ERR) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) != 0);
      s   = ($urandom_range(0, 9) < 2);
      stp = ($urandom_range(0, 9) < 7);
      z   = $urandom_range(0, 1);
      tick(r, s, stp, $urandom_range(0, 7), $urandom_range(0, (1 << AW) - 1), z);
      checks++;
      if ({addr, running, halted, depth, stack_ovf, stack_unf} !==
          {9'(m_addr), m_st == M_RUN, m_st == M_HALT, 3'(m_stk.size()), m_ovf, m_unf}) begin
        errors++;
        $display("FAIL random_%0d: addr=%0d run=%b halt=%b depth=%0d ovf=%b unf=%b, want %0d %b %b %0d %b %b",
                 n, addr, running, halted, depth, stack_ovf, stack_unf,
                 m_addr, m_st == M_RUN, m_st == M_HALT, m_stk.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_next();
    test_wrap();
    test_brz();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
